// File: rtl/sp_ram_param.sv
// sp_ram_param: parametrised single-port RAM with byte-enable writes,
// selectable read-during-write behaviour, out-of-range detection and an
// automatic zero-fill sweep after reset or on clr_i.
//
// Optional feature macro: SP_RAM_OUT_REG_EN
//   defined     -> extra output register stage (read latency 2)
//   not defined -> read latency 1
//
// Behaviour of an out-of-range write when READ_MODE is 1 or 2: the write is
// dropped and the readback treats the missing word as zero, so data_o gets 0
// with an rvalid_o pulse. This matches what an out-of-range read returns.

module sp_ram_param #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 3,
  parameter int DEPTH     = 8,
  parameter int READ_MODE = 0
) (
  input  logic                clk_pi,
  input  logic                rst_pi,
  input  logic                en_i,
  input  logic                we_pi,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   data_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic                clr_i,
  output logic                ready_o,
  output logic [DATA_W-1:0]   data_o,
  output logic                rvalid_o,
  output logic                err_o
);

  localparam int NBYTES = DATA_W / 8;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_L  = IDX_W'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_nextPtr;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_accept;
  logic              w_inRange;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_oldWord;
  logic [DATA_W-1:0] w_rdWord;
  logic [DATA_W-1:0] w_merged;

  logic [DATA_W-1:0] r_data;
  logic              r_rvalid;
  logic              r_err;

  // Requests are only taken while the sweep is not running.
  assign ready_o   = (r_state == S_READY);
  assign w_accept  = en_i & ready_o;
  assign w_inRange = ({1'b0, addr_i} < DEPTH_L);
  assign w_idx     = addr_i[IDX_W-1:0];
  assign w_oldWord = r_mem[w_idx];
  assign w_rdWord  = w_inRange ? w_oldWord : '0;

  // State register and sweep pointer; reset restarts the sweep from word 0.
  always_ff @(posedge clk_pi or posedge rst_pi) begin
    if (rst_pi) begin
      r_state <= S_CLEAR;
      r_ptr   <= '0;
    end else begin
      r_state <= w_nextState;
      r_ptr   <= w_nextPtr;
    end
  end

  // Next-state logic: sweep one word per cycle, leave after the last word,
  // and re-enter the sweep on clr_i only from READY.
  always_comb begin
    w_nextState = r_state;
    w_nextPtr   = r_ptr;
    case (r_state)
      S_CLEAR: begin
        if (r_ptr == LAST_L) begin
          w_nextState = S_READY;
          w_nextPtr   = '0;
        end else begin
          w_nextPtr = r_ptr + IDX_W'(1);
        end
      end
      S_READY: begin
        if (clr_i) begin
          w_nextState = S_CLEAR;
          w_nextPtr   = '0;
        end
      end
      default: begin
        w_nextState = S_CLEAR;
        w_nextPtr   = '0;
      end
    endcase
  end

  // Byte-enable merge of the incoming data over the currently stored word.
  always_comb begin
    w_merged = w_oldWord;
    for (int k = 0; k < NBYTES; k++) begin
      if (be_i[k]) begin
        w_merged[8*k +: 8] = data_i[8*k +: 8];
      end
    end
  end

  // Storage array: zero-fill during the sweep, byte-merged writes when ready.
  always_ff @(posedge clk_pi) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_ptr] <= '0;
    end else if (w_accept && we_pi && w_inRange) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  // First output stage: read data, readback according to READ_MODE, and the
  // one-cycle rvalid/err pulses. data holds whenever nothing is returned.
  always_ff @(posedge clk_pi or posedge rst_pi) begin
    if (rst_pi) begin
      r_data   <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      if (w_accept) begin
        r_err <= ~w_inRange;
        if (!we_pi) begin
          r_data   <= w_rdWord;
          r_rvalid <= 1'b1;
        end else if (READ_MODE == 1) begin
          r_data   <= w_rdWord;
          r_rvalid <= 1'b1;
        end else if (READ_MODE == 2) begin
          r_data   <= w_inRange ? w_merged : '0;
          r_rvalid <= 1'b1;
        end
      end
    end
  end

`ifdef SP_RAM_OUT_REG_EN
  logic [DATA_W-1:0] r_dataQ;
  logic              r_rvalidQ;
  logic              r_errQ;

  // Extra output register stage; reset discards anything still in flight.
  always_ff @(posedge clk_pi or posedge rst_pi) begin
    if (rst_pi) begin
      r_dataQ   <= '0;
      r_rvalidQ <= 1'b0;
      r_errQ    <= 1'b0;
    end else begin
      r_dataQ   <= r_data;
      r_rvalidQ <= r_rvalid;
      r_errQ    <= r_err;
    end
  end

  assign data_o   = r_dataQ;
  assign rvalid_o = r_rvalidQ;
  assign err_o    = r_errQ;
`else
  assign data_o   = r_data;
  assign rvalid_o = r_rvalid;
  assign err_o    = r_err;
`endif

endmodule

// File: tb/tb_sp_ram_param.sv
// tb_sp_ram_param: three instances (READ_MODE 0, 1, 2; DEPTH 6) driven with
// identical stimulus and compared against a behavioural model of the RAM.

module tb_sp_ram_param;

  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 6;
`ifdef SP_RAM_OUT_REG_EN
  localparam bit OUTREG = 1'b1;
`else
  localparam bit OUTREG = 1'b0;
`endif

  logic          clk_pi = 1'b0;
  logic          rst_pi = 1'b0;
  logic          en_i   = 1'b0;
  logic          we_pi  = 1'b0;
  logic [AW-1:0] addr_i = '0;
  logic [DW-1:0] data_i = '0;
  logic [1:0]    be_i   = '0;
  logic          clr_i  = 1'b0;

  logic          rdy  [3];
  logic [DW-1:0] dOut [3];
  logic          rv   [3];
  logic          er   [3];

  always #5 clk_pi = ~clk_pi;

  sp_ram_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .READ_MODE(0)) m0 (
    .clk_pi(clk_pi), .rst_pi(rst_pi), .en_i(en_i), .we_pi(we_pi), .addr_i(addr_i),
    .data_i(data_i), .be_i(be_i), .clr_i(clr_i), .ready_o(rdy[0]), .data_o(dOut[0]),
    .rvalid_o(rv[0]), .err_o(er[0]));
  sp_ram_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .READ_MODE(1)) m1 (
    .clk_pi(clk_pi), .rst_pi(rst_pi), .en_i(en_i), .we_pi(we_pi), .addr_i(addr_i),
    .data_i(data_i), .be_i(be_i), .clr_i(clr_i), .ready_o(rdy[1]), .data_o(dOut[1]),
    .rvalid_o(rv[1]), .err_o(er[1]));
  sp_ram_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .READ_MODE(2)) m2 (
    .clk_pi(clk_pi), .rst_pi(rst_pi), .en_i(en_i), .we_pi(we_pi), .addr_i(addr_i),
    .data_i(data_i), .be_i(be_i), .clr_i(clr_i), .ready_o(rdy[2]), .data_o(dOut[2]),
    .rvalid_o(rv[2]), .err_o(er[2]));

  int nPass  = 0;
  int nTotal = 0;

  // Behavioural model state
  int            clearLeft;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] s1D [3];
  logic          s1R [3];
  logic          s1E;
  logic [DW-1:0] oD  [3];
  logic          oR  [3];
  logic          oE;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTotal++;
    assert (obs === exp) nPass++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic modelReset();
    clearLeft = DEPTH;
    for (int m = 0; m < 3; m++) begin
      s1D[m] = '0; s1R[m] = 1'b0; oD[m] = '0; oR[m] = 1'b0;
    end
    s1E = 1'b0;
    oE  = 1'b0;
  endtask

  // One clock edge of the reference model, using the inputs held before it.
  task automatic modelEdge(input logic en, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input logic [1:0] be, input logic clr);
    logic          acc, inR;
    logic [DW-1:0] oldW, newW, mask;
    logic [DW-1:0] nD [3];
    logic          nR [3];
    logic          nE;
    acc  = en && (clearLeft == 0);
    inR  = (int'(addr) < DEPTH);
    oldW = inR ? mem[addr] : 16'h0000;
    newW = oldW;
    for (int k = 0; k < 2; k++) begin
      mask = 16'h00FF << (8 * k);
      if (be[k]) newW = (newW & ~mask) | (data & mask);
    end
    if (!inR) newW = 16'h0000;
    nE = acc && !inR;
    for (int m = 0; m < 3; m++) begin
      nD[m] = s1D[m];
      nR[m] = 1'b0;
      if (acc) begin
        if (!we) begin
          nD[m] = oldW; nR[m] = 1'b1;
        end else if (m == 1) begin
          nD[m] = oldW; nR[m] = 1'b1;
        end else if (m == 2) begin
          nD[m] = newW; nR[m] = 1'b1;
        end
      end
    end
    if (clearLeft > 0) begin
      mem[DEPTH - clearLeft] = 16'h0000;
      clearLeft--;
    end else begin
      if (acc && we && inR) mem[addr] = newW;
      if (clr) clearLeft = DEPTH;
    end
    for (int m = 0; m < 3; m++) begin
      if (OUTREG) begin
        oD[m] = s1D[m]; oR[m] = s1R[m];
      end else begin
        oD[m] = nD[m]; oR[m] = nR[m];
      end
      s1D[m] = nD[m];
      s1R[m] = nR[m];
    end
    oE  = OUTREG ? s1E : nE;
    s1E = nE;
  endtask

  // Drive one cycle of inputs, check ready before the edge and outputs after it.
  task automatic applyStimulus(input logic en, input logic we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data, input logic [1:0] be, input logic clr);
    en_i = en; we_pi = we; addr_i = addr; data_i = data; be_i = be; clr_i = clr;
    for (int m = 0; m < 3; m++)
      checkOutput($sformatf("ready_m%0d", m), 32'(rdy[m]), 32'(clearLeft == 0));
    @(posedge clk_pi);
    #1;
    modelEdge(en, we, addr, data, be, clr);
    for (int m = 0; m < 3; m++) begin
      checkOutput($sformatf("data_m%0d", m), 32'(dOut[m]), 32'(oD[m]));
      checkOutput($sformatf("rvalid_m%0d", m), 32'(rv[m]), 32'(oR[m]));
      checkOutput($sformatf("err_m%0d", m), 32'(er[m]), 32'(oE));
    end
    en_i = 1'b0; clr_i = 1'b0;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b0);
  endtask

  task automatic flushPipe();
    if (OUTREG) idle();
  endtask

  // Assert reset between edges, hold it across one edge, then release.
  task automatic doReset();
    rst_pi = 1'b1; en_i = 1'b0; clr_i = 1'b0;
    modelReset();
    #1;
    for (int m = 0; m < 3; m++) begin
      checkOutput($sformatf("rst_data_m%0d", m), 32'(dOut[m]), 32'h0);
      checkOutput($sformatf("rst_rvalid_m%0d", m), 32'(rv[m]), 32'h0);
      checkOutput($sformatf("rst_err_m%0d", m), 32'(er[m]), 32'h0);
      checkOutput($sformatf("rst_ready_m%0d", m), 32'(rdy[m]), 32'h0);
    end
    @(posedge clk_pi);
    #1;
    rst_pi = 1'b0;
  endtask

  // Idle until ready rises (bounded) and check the sweep length.
  task automatic waitSweep(input string tag);
    int cnt;
    cnt = 0;
    while (rdy[0] !== 1'b1 && cnt < 40) begin
      idle();
      cnt++;
    end
    checkOutput(tag, 32'(cnt), 32'(DEPTH));
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'hDEAD;
    modelReset();

    // Reset release, sweep length, and all words zero
    doReset();
    waitSweep("t1_sweepCycles");
    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(1'b1, 1'b0, AW'(a), 16'h0000, 2'b00, 1'b0);
      flushPipe();
      checkOutput($sformatf("t1_zero_a%0d", a), 32'(dOut[0]), 32'h0000);
    end
    idle();

    // Byte-enable merge
    applyStimulus(1'b1, 1'b1, 3'd2, 16'hABCD, 2'b11, 1'b0);
    applyStimulus(1'b1, 1'b1, 3'd2, 16'h1234, 2'b01, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'd2, 16'h0000, 2'b00, 1'b0);
    flushPipe();
    checkOutput("t2_merge", 32'(dOut[0]), 32'hAB34);
    checkOutput("t2_rvalid", 32'(rv[0]), 32'h1);
    idle();
    checkOutput("t2_rvalidOnce", 32'(rv[0]), 32'h0);
    checkOutput("t2_hold", 32'(dOut[0]), 32'hAB34);

    // Out-of-range write and read
    applyStimulus(1'b1, 1'b1, 3'd7, 16'h5555, 2'b11, 1'b0);
    flushPipe();
    checkOutput("t3_wrErr", 32'(er[0]), 32'h1);
    applyStimulus(1'b1, 1'b0, 3'd6, 16'h0000, 2'b00, 1'b0);
    flushPipe();
    checkOutput("t3_rdData", 32'(dOut[0]), 32'h0000);
    checkOutput("t3_rdValid", 32'(rv[0]), 32'h1);
    checkOutput("t3_rdErr", 32'(er[0]), 32'h1);
    idle();

    // Read-during-write modes
    applyStimulus(1'b1, 1'b1, 3'd1, 16'h1111, 2'b11, 1'b0);
    applyStimulus(1'b1, 1'b1, 3'd1, 16'h0F0F, 2'b11, 1'b0);
    flushPipe();
    checkOutput("t4_readFirst", 32'(dOut[1]), 32'h1111);
    checkOutput("t4_writeFirst", 32'(dOut[2]), 32'h0F0F);
    checkOutput("t4_noChangeRv", 32'(rv[0]), 32'h0);
    idle();

    // Back-to-back reads
    applyStimulus(1'b1, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'd1, 16'h0000, 2'b00, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'd2, 16'h0000, 2'b00, 1'b0);
    idle();
    idle();

    // Clear, reset mid-sweep, requests dropped during the sweep
    applyStimulus(1'b1, 1'b1, 3'd3, 16'h3333, 2'b11, 1'b0);
    applyStimulus(1'b1, 1'b1, 3'd4, 16'h4444, 2'b11, 1'b0);
    applyStimulus(1'b1, 1'b1, 3'd5, 16'h5555, 2'b11, 1'b1);
    applyStimulus(1'b1, 1'b1, 3'd0, 16'h7777, 2'b11, 1'b1);
    applyStimulus(1'b1, 1'b1, 3'd1, 16'h8888, 2'b11, 1'b0);
    doReset();
    waitSweep("t5_sweepCycles");
    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(1'b1, 1'b0, AW'(a), 16'h0000, 2'b00, 1'b0);
      flushPipe();
      checkOutput($sformatf("t5_zero_a%0d", a), 32'(dOut[0]), 32'h0000);
    end

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        doReset();
      end else begin
        applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                      AW'($urandom_range(0, 7)), 16'($urandom), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 49) == 0));
      end
    end
    idle();
    idle();

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
